ascii_ps2_tx: RTL and testbench

Keystroke emulator that performs the reverse of the PS/2 scan-code-to-ASCII decode. It accepts one ASCII character and returns it to Set-2 scan code. It transmits the full keystroke (make code, 0xF0, make code) as three device-to-host PS/2 frames on open-collector-style clock and data levels. It sits between a character source (UART/console logic) and the PS/2 port pins or a loopback into the keyboard receive chain.

---
 rtl/ascii_ps2_tx_if.sv | 28 ++
 rtl/ascii_ps2_tx.sv | 159 +++++++++++++++
 tb/tb_ascii_ps2_tx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ascii_ps2_tx_if.sv
// Character-side handshake and PS/2 line levels for the ASCII-to-PS/2 keystroke emulator.
// The master is the character source / line observer; the slave is the emulator itself.
interface ascii_ps2_tx_if;
  logic [7:0] Ascii_Code;
  logic       Ascii_Valid;
  logic       Busy;
  logic       Invalid_Code;
  logic       Ps2_Clk;
  logic       Ps2_Data;

  modport master (
    output Ascii_Code,
    output Ascii_Valid,
    input  Busy,
    input  Invalid_Code,
    input  Ps2_Clk,
    input  Ps2_Data
  );

  modport slave (
    input  Ascii_Code,
    input  Ascii_Valid,
    output Busy,
    output Invalid_Code,
    output Ps2_Clk,
    output Ps2_Data
  );
endinterface

// File: rtl/ascii_ps2_tx.sv
// ASCII keystroke emulator: maps one character to its Set-2 make code and sends
// make, 0xF0, make as three device-to-host PS/2 frames separated by idle gaps.
module ascii_ps2_tx #(
  parameter int CLK_DIV = 4000,
  parameter int GAP_CYC = 10000
) (
  input logic           Clk_T,
  input logic           Reset_T,
  ascii_ps2_tx_if.slave bus
);

  localparam int HALF_W = $clog2(CLK_DIV);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t            state;
  state_t            state_next;
  logic [7:0]        scan_code;
  logic [1:0]        byte_idx;
  logic [3:0]        bit_cnt;
  logic [HALF_W-1:0] half_cnt;
  logic              low_phase;
  logic [GAP_W-1:0]  gap_cnt;
  logic              invalid_q;

  logic [7:0]  map_code;
  logic        map_hit;
  logic        accept;
  logic        half_end;
  logic        frame_end;
  logic        gap_end;
  logic [7:0]  tx_byte;
  logic [15:0] frame_bits;

  assign accept    = bus.Ascii_Valid && (state == IDLE);
  assign half_end  = (half_cnt == HALF_LAST);
  assign frame_end = half_end && low_phase && (bit_cnt == 4'd10);
  assign gap_end   = (gap_cnt == GAP_LAST);

  // Byte index 1 is always the break prefix; the other two repeat the make code.
  assign tx_byte    = (byte_idx == 2'd1) ? 8'hF0 : scan_code;
  assign frame_bits = {5'h1F, 1'b1, ~^tx_byte, tx_byte, 1'b0};

  assign bus.Busy         = (state != IDLE);
  assign bus.Invalid_Code = invalid_q;
  assign bus.Ps2_Clk      = (state == SEND) ? ~low_phase : 1'b1;
  assign bus.Ps2_Data     = (state == SEND) ? frame_bits[bit_cnt] : 1'b1;

  // Character to Set-2 make code lookup; upper and lower case letters share codes.
  always_comb begin
    map_code = 8'h00;
    map_hit  = 1'b1;
    case (bus.Ascii_Code)
      8'h30: map_code = 8'h45;  8'h31: map_code = 8'h16;
      8'h32: map_code = 8'h1E;  8'h33: map_code = 8'h26;
      8'h34: map_code = 8'h25;  8'h35: map_code = 8'h2E;
      8'h36: map_code = 8'h36;  8'h37: map_code = 8'h3D;
      8'h38: map_code = 8'h3E;  8'h39: map_code = 8'h46;
      8'h41, 8'h61: map_code = 8'h1C;  8'h42, 8'h62: map_code = 8'h32;
      8'h43, 8'h63: map_code = 8'h21;  8'h44, 8'h64: map_code = 8'h23;
      8'h45, 8'h65: map_code = 8'h24;  8'h46, 8'h66: map_code = 8'h2B;
      8'h47, 8'h67: map_code = 8'h34;  8'h48, 8'h68: map_code = 8'h33;
      8'h49, 8'h69: map_code = 8'h43;  8'h4A, 8'h6A: map_code = 8'h3B;
      8'h4B, 8'h6B: map_code = 8'h42;  8'h4C, 8'h6C: map_code = 8'h4B;
      8'h4D, 8'h6D: map_code = 8'h3A;  8'h4E, 8'h6E: map_code = 8'h31;
      8'h4F, 8'h6F: map_code = 8'h44;  8'h50, 8'h70: map_code = 8'h4D;
      8'h51, 8'h71: map_code = 8'h15;  8'h52, 8'h72: map_code = 8'h2D;
      8'h53, 8'h73: map_code = 8'h1B;  8'h54, 8'h74: map_code = 8'h2C;
      8'h55, 8'h75: map_code = 8'h3C;  8'h56, 8'h76: map_code = 8'h2A;
      8'h57, 8'h77: map_code = 8'h1D;  8'h58, 8'h78: map_code = 8'h22;
      8'h59, 8'h79: map_code = 8'h35;  8'h5A, 8'h7A: map_code = 8'h1A;
      8'h20: map_code = 8'h29;  8'h0D: map_code = 8'h5A;
      8'h08: map_code = 8'h66;  8'h2D: map_code = 8'h4E;
      8'h3D: map_code = 8'h55;  8'h5B: map_code = 8'h54;
      8'h5D: map_code = 8'h5B;  8'h5C: map_code = 8'h5D;
      8'h3B: map_code = 8'h4C;  8'h27: map_code = 8'h52;
      8'h2C: map_code = 8'h41;  8'h2E: map_code = 8'h49;
      8'h2F: map_code = 8'h4A;  8'h60: map_code = 8'h0E;
      default: map_hit = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge Clk_T or negedge Reset_T) begin
    if (!Reset_T) state <= IDLE;
    else          state <= state_next;
  end

  // Next state: three frames with a gap between each, no gap after the last one.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && map_hit) state_next = SEND;
      SEND: if (frame_end)         state_next = (byte_idx == 2'd2) ? IDLE : GAP;
      GAP:  if (gap_end)           state_next = SEND;
      default:                     state_next = IDLE;
    endcase
  end

  // Datapath: scan-code latch, half-period, bit, byte and gap counters, reject pulse.
  always_ff @(posedge Clk_T or negedge Reset_T) begin
    if (!Reset_T) begin
      scan_code <= 8'h00;
      byte_idx  <= 2'd0;
      bit_cnt   <= 4'd0;
      half_cnt  <= '0;
      low_phase <= 1'b0;
      gap_cnt   <= '0;
      invalid_q <= 1'b0;
    end else begin
      invalid_q <= accept && !map_hit;
      case (state)
        IDLE: begin
          if (accept && map_hit) begin
            scan_code <= map_code;
            byte_idx  <= 2'd0;
            bit_cnt   <= 4'd0;
            half_cnt  <= '0;
            low_phase <= 1'b0;
            gap_cnt   <= '0;
          end
        end
        SEND: begin
          if (half_end) begin
            half_cnt  <= '0;
            low_phase <= ~low_phase;
            if (low_phase) begin
              if (bit_cnt == 4'd10) begin
                bit_cnt <= 4'd0;
                gap_cnt <= '0;
                if (byte_idx != 2'd2) byte_idx <= byte_idx + 2'd1;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end else begin
            half_cnt <= half_cnt + HALF_W'(1);
          end
        end
        GAP: begin
          if (gap_end) begin
            gap_cnt   <= '0;
            half_cnt  <= '0;
            low_phase <= 1'b0;
            bit_cnt   <= 4'd0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_ps2_tx.sv
// Randomised scoreboard bench for ascii_ps2_tx: a reference model predicts frames and
// reject pulses, and a host-style monitor decodes the PS/2 lines and compares.
module tb_ascii_ps2_tx;
  localparam int CLK_DIV    = 4;
  localparam int GAP_CYC    = 8;
  localparam int DUR        = 66 * CLK_DIV + 2 * GAP_CYC;
  localparam int FRAME_SPAN = 22 * CLK_DIV + GAP_CYC;

  typedef struct {
    logic [7:0] data;
    int         first_fall;
  } frame_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ascii_ps2_tx_if bus ();

  ascii_ps2_tx #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .Clk_T   (clk),
    .Reset_T (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc      = 0;
  int busy_end = 0;
  int tests    = 0;
  int fails    = 0;

  frame_t     frame_q[$];
  int         invalid_q[$];
  logic [7:0] ref_map[int];
  int         mapped_keys[$];

  logic [7:0] digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                  8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                   8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                   8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                   8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] punct_chars[14] = '{8'h20, 8'h0D, 8'h08, 8'h2D, 8'h3D, 8'h5B, 8'h5D,
                                  8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F, 8'h60};
  logic [7:0] punct_codes[14] = '{8'h29, 8'h5A, 8'h66, 8'h4E, 8'h55, 8'h54, 8'h5B,
                                  8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h0E};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int required);
    tests++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) wait_cycles(1);
  endtask

  // Reference model: a strobe sampled on a clock edge after the previous keystroke's
  // busy window is accepted; mapped codes yield three frames, unmapped a reject pulse.
  task automatic model_strobe(input logic [7:0] code, input int edge_idx);
    logic [7:0] mk;
    if (edge_idx > busy_end) begin
      if (ref_map.exists(int'(code))) begin
        mk = ref_map[int'(code)];
        frame_q.push_back('{mk,    edge_idx + CLK_DIV});
        frame_q.push_back('{8'hF0, edge_idx + FRAME_SPAN + CLK_DIV});
        frame_q.push_back('{mk,    edge_idx + 2 * FRAME_SPAN + CLK_DIV});
        busy_end = edge_idx + DUR;
      end else begin
        invalid_q.push_back(edge_idx);
      end
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] code);
    bus.Ascii_Code  = code;
    bus.Ascii_Valid = 1'b1;
    wait_cycles(1);
    bus.Ascii_Valid = 1'b0;
    bus.Ascii_Code  = 8'($urandom);
    model_strobe(code, cyc);
  endtask

  // Host-side monitor: per-cycle busy/idle expectations, reject pulses, frame decoding.
  initial begin
    logic        prev_clk;
    logic [10:0] bits;
    int          bit_n;
    int          first_fall;
    int          last_fall;
    frame_t      exp;
    prev_clk = 1'b1;
    bits = '0;
    bit_n = 0;
    first_fall = 0;
    last_fall = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_clk = 1'b1;
        bit_n = 0;
      end else begin
        if (cyc >= busy_end) begin
          check_output("idle_busy", bus.Busy, 0);
          check_output("idle_lines", {bus.Ps2_Clk, bus.Ps2_Data}, 2'b11);
        end else begin
          check_output("busy_window", bus.Busy, 1);
        end
        if (bus.Invalid_Code) begin
          if (invalid_q.size() == 0) check_output("invalid_unexpected", 1, 0);
          else check_output("invalid_cycle", cyc, invalid_q.pop_front());
        end
        if (prev_clk && !bus.Ps2_Clk) begin
          if (bit_n == 0) first_fall = cyc;
          bits[bit_n] = bus.Ps2_Data;
          last_fall = cyc;
          bit_n++;
          if (bit_n == 11) begin
            bit_n = 0;
            if (frame_q.size() == 0) begin
              check_output("frame_unexpected", 1, 0);
            end else begin
              exp = frame_q.pop_front();
              check_output("frame_start", bits[0], 0);
              check_output("frame_data", bits[8:1], exp.data);
              check_output("frame_parity", bits[9], ($countones(exp.data) % 2 == 0) ? 1 : 0);
              check_output("frame_stop", bits[10], 1);
              check_output("frame_first_fall", first_fall, exp.first_fall);
              check_output("frame_fall_span", last_fall - first_fall, 20 * CLK_DIV);
            end
          end
        end
        prev_clk = bus.Ps2_Clk;
      end
    end
  end

  // Directed scenarios followed by randomised strobes, including strobes while busy.
  initial begin
    for (int i = 0; i < 10; i++) begin
      ref_map[8'h30 + i] = digit_codes[i];
    end
    for (int i = 0; i < 26; i++) begin
      ref_map[8'h41 + i] = letter_codes[i];
      ref_map[8'h61 + i] = letter_codes[i];
    end
    for (int i = 0; i < 14; i++) ref_map[int'(punct_chars[i])] = punct_codes[i];
    foreach (ref_map[k]) mapped_keys.push_back(k);

    bus.Ascii_Code  = 8'h00;
    bus.Ascii_Valid = 1'b0;
    rst_n = 1'b0;
    wait_cycles(3);
    check_output("reset_busy", bus.Busy, 0);
    check_output("reset_invalid", bus.Invalid_Code, 0);
    check_output("reset_ps2_clk", bus.Ps2_Clk, 1);
    check_output("reset_ps2_data", bus.Ps2_Data, 1);
    rst_n = 1'b1;
    wait_cycles(2);

    apply_stimulus(8'h41);
    wait_until(busy_end + 5);

    apply_stimulus(8'h30);
    wait_until(busy_end);
    apply_stimulus(8'h0D);
    wait_until(busy_end + 5);

    apply_stimulus(8'h7F);
    wait_cycles(300);

    apply_stimulus(8'h41);
    wait_cycles(FRAME_SPAN + 10);
    apply_stimulus(8'h7A);
    wait_until(busy_end + 3);
    apply_stimulus(8'h7A);
    wait_until(busy_end + 5);

    apply_stimulus(8'h41);
    wait_cycles(9 * CLK_DIV);
    #2;
    rst_n = 1'b0;
    frame_q.delete();
    invalid_q.delete();
    busy_end = cyc;
    #1;
    check_output("midreset_busy", bus.Busy, 0);
    check_output("midreset_invalid", bus.Invalid_Code, 0);
    check_output("midreset_ps2_clk", bus.Ps2_Clk, 1);
    check_output("midreset_ps2_data", bus.Ps2_Data, 1);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(100);
    apply_stimulus(8'h08);
    wait_until(busy_end + 5);

    for (int n = 0; n < 16; n++) begin
      logic [7:0] code;
      if ($urandom_range(0, 1) == 1)
        code = 8'(mapped_keys[$urandom_range(0, mapped_keys.size() - 1)]);
      else
        code = 8'($urandom_range(0, 255));
      apply_stimulus(code);
      wait_cycles($urandom_range(1, DUR + 20));
    end
    wait_until(busy_end + 10);

    check_output("frames_left", frame_q.size(), 0);
    check_output("invalid_left", invalid_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
